execute_stage: RTL and testbench

Execute stage of the five-stage pipelined Y86-64 processor. Sits between the decode/E pipeline register and the memory stage. Selects ALU operands, evaluates add/sub/and/xor through the 64-bit ALU, and maintains the ZF/SF/OF condition-code register. Evaluates branch/cmov conditions and registers results into the M pipeline register under hazard-unit stall/bubble control.

---
 rtl/y86_pkg.sv | 71 +++++++
 rtl/alu_64bit.sv | 48 ++++
 rtl/execute_stage.sv | 131 +++++++++++++
 tb/tb_execute_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 encodings, condition-code type and condition helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Branch / conditional-move predicate evaluated against a CC snapshot.
  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | cc.zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = cc.zf;
      C_NE:     cond_eval = ~cc.zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~cc.zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_64bit.sv
// ============================================================================
// Module : alu_64bit
// Brief  : Combinational add/sub/and/xor ALU computing b OP a with ZF/SF/OF.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_64bit
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fun_t         fun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    result = b + a;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // Subtraction order is b - a so that "subq rA,rB" yields rB - rA.
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = b + a;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[MSB];

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module : execute_stage
// Brief  : Y86-64 execute stage: operand select, ALU, CC register, condition
//          evaluation and the M pipeline register with stall/bubble control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module execute_stage
  import y86_pkg::*;
#(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_stat_exc,
  input  logic             W_stat_exc,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [WIDTH-1:0] C_POS_EIGHT = WIDTH'(8);
  localparam logic [WIDTH-1:0] C_NEG_EIGHT = WIDTH'(-8);

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  alu_fun_t         w_alu_fun;
  logic             w_zf;
  logic             w_sf;
  logic             w_of;
  logic             w_set_cc;
  cc_t              r_cc;

  always_comb begin
    w_alu_a = '0;
    case (E_icode)
      I_CMOVXX, I_OPQ:             w_alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC;
      I_CALL, I_PUSHQ:             w_alu_a = C_NEG_EIGHT;
      I_RET, I_POPQ:               w_alu_a = C_POS_EIGHT;
      default:                     w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_PUSHQ, I_RET, I_POPQ: w_alu_b = E_valB;
      default:                        w_alu_b = '0;
    endcase
  end

  assign w_alu_fun = (E_icode == I_OPQ) ? alu_fun_t'(E_ifun[1:0]) : ALU_ADD;

  alu_64bit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .fun    (w_alu_fun),
    .result (e_valE),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  // An exception further down the pipe must not let a younger OPQ alter flags.
  assign w_set_cc = (E_icode == I_OPQ) && !m_stat_exc && !W_stat_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_set_cc) begin
      r_cc <= '{zf: w_zf, sf: w_sf, of: w_of};
    end
  end

  assign e_Cnd  = cond_eval(E_ifun, r_cc);
  assign e_dstE = ((E_icode == I_CMOVXX) && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module : tb_execute_stage
// Brief  : Self-checking bench for execute_stage with an M-register scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        m_stat_exc, W_stat_exc, M_stall, M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  execute_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat_exc(m_stat_exc), .W_stat_exc(W_stat_exc),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } mreg_t;

  localparam mreg_t BUBBLE = '{stat: 3'd1, icode: 4'h1, cnd: 1'b0, vale: 64'd0,
                               vala: 64'd0, dste: 4'hF, dstm: 4'hF};

  mreg_t sb[$];
  mreg_t m_cur;
  logic  c_zf, c_sf, c_of;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_m(input string tag, input mreg_t e);
    check({tag, ".stat"},  {61'd0, M_stat},  {61'd0, e.stat});
    check({tag, ".icode"}, {60'd0, M_icode}, {60'd0, e.icode});
    check({tag, ".cnd"},   {63'd0, M_Cnd},   {63'd0, e.cnd});
    check({tag, ".valE"},  M_valE, e.vale);
    check({tag, ".valA"},  M_valA, e.vala);
    check({tag, ".dstE"},  {60'd0, M_dstE},  {60'd0, e.dste});
    check({tag, ".dstM"},  {60'd0, M_dstM},  {60'd0, e.dstm});
  endtask

  task automatic idle_inputs();
    E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0;
    E_valA = '0; E_valB = '0; E_valC = '0; E_dstE = 4'hF; E_dstM = 4'hF;
    m_stat_exc = 1'b0; W_stat_exc = 1'b0; M_stall = 1'b1; M_bubble = 1'b0;
  endtask

  // Reset asserted a few ns after a rising edge; outputs must go to bubble at once.
  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_m("reset", BUBBLE);
    sb.delete();
    m_cur = BUBBLE;
    c_zf = 1'b1; c_sf = 1'b0; c_of = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st,
                       input logic mx, input logic wx, input logic stl, input logic bub);
    logic [63:0] a, b, r;
    logic [64:0] w;
    logic        zf, sf, of, cnd, lt;
    logic [3:0]  dste;
    mreg_t       nx, exp;
    @(negedge clk);
    E_stat = st; E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm; m_stat_exc = mx; W_stat_exc = wx;
    M_stall = stl; M_bubble = bub;
    #1;
    case (ic)
      4'h2, 4'h6:       a = va;
      4'h3, 4'h4, 4'h5: a = vc;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    case (ic)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: b = vb;
      default:                                  b = 64'd0;
    endcase
    of = 1'b0;
    if (ic == 4'h6 && fn == 4'd1) begin
      w = {b[63], b} - {a[63], a};
      r = w[63:0];
      of = w[64] ^ w[63];
    end else if (ic == 4'h6 && fn == 4'd2) begin
      r = a & b;
    end else if (ic == 4'h6 && fn == 4'd3) begin
      r = a ^ b;
    end else begin
      w = {a[63], a} + {b[63], b};
      r = w[63:0];
      of = w[64] ^ w[63];
    end
    zf = (r == 64'd0);
    sf = r[63];
    lt = (c_sf != c_of);
    case (fn)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt || c_zf;
      4'd2:    cnd = lt;
      4'd3:    cnd = c_zf;
      4'd4:    cnd = !c_zf;
      4'd5:    cnd = !lt;
      4'd6:    cnd = !lt && !c_zf;
      default: cnd = 1'b0;
    endcase
    dste = (ic == 4'h2 && !cnd) ? 4'hF : de;
    check({tag, ".e_valE"}, e_valE, r);
    check({tag, ".e_Cnd"},  {63'd0, e_Cnd},  {63'd0, cnd});
    check({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, dste});
    if (bub)      nx = BUBBLE;
    else if (stl) nx = m_cur;
    else          nx = '{stat: st, icode: ic, cnd: cnd, vale: r, vala: va, dste: dste, dstm: dm};
    sb.push_back(nx);
    @(posedge clk);
    #1;
    if (ic == 4'h6 && !mx && !wx) begin
      c_zf = zf; c_sf = sf; c_of = of;
    end
    exp = sb.pop_front();
    check_m(tag, exp);
    m_cur = exp;
  endtask

  // Shorthand for an ordinary AOK instruction with no stall/bubble/exception.
  task automatic op(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                    input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                    input logic [3:0] de, input logic [3:0] dm);
    drive(tag, ic, fn, va, vb, vc, de, dm, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ic, fn;
    do_reset();
    op("rst_je", 4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    op("rst_jl", 4'h7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);

    op("add_ovf", 4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3, 4'hF);
    op("jle_after", 4'h7, 4'd1, 64'h11, 64'd0, 64'h40, 4'hF, 4'hF);
    op("jl_after",  4'h7, 4'd2, 64'h11, 64'd0, 64'h40, 4'hF, 4'hF);
    op("jne_after", 4'h7, 4'd4, 64'h11, 64'd0, 64'h40, 4'hF, 4'hF);

    op("xor_zero", 4'h6, 4'd3, 64'h3, 64'h3, 64'd0, 4'h1, 4'hF);
    op("je_after", 4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);

    drive("sub_wexc", 4'h6, 4'd1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("sub_mexc", 4'h6, 4'd1, 64'd7, 64'd5, 64'd0, 4'h2, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    op("je_kept", 4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);

    op("sub_neg", 4'h6, 4'd1, 64'd5, 64'd3, 64'd0, 4'h4, 4'hF);
    op("jl_neg",  4'h7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    op("and_op",  4'h6, 4'd2, 64'hF0F0, 64'hFF00, 64'd0, 4'h5, 4'hF);
    op("sub_ovf", 4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h6, 4'hF);
    op("jg_ovf",  4'h7, 4'd6, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);

    op("pushq", 4'hA, 4'd0, 64'h55, 64'h100, 64'd0, 4'h4, 4'hF);
    op("popq",  4'hB, 4'd0, 64'h55, 64'hF8, 64'd0, 4'h4, 4'h7);
    op("call",  4'h8, 4'd0, 64'h20, 64'h200, 64'h300, 4'h4, 4'hF);
    op("ret",   4'h9, 4'd0, 64'h1F8, 64'h1F8, 64'd0, 4'h4, 4'hF);
    op("irmovq", 4'h3, 4'd0, 64'h9, 64'h9, 64'hDEAD_BEEF, 4'h2, 4'hF);
    op("mrmovq", 4'h5, 4'd0, 64'h9, 64'h1000, 64'h18, 4'hF, 4'h3);

    op("xor_nz",  4'h6, 4'd3, 64'h1, 64'h3, 64'd0, 4'h1, 4'hF);
    op("cmove_sq", 4'h2, 4'd3, 64'h77, 64'h0, 64'd0, 4'h2, 4'hF);
    op("rrmovq",   4'h2, 4'd0, 64'h77, 64'h0, 64'd0, 4'h2, 4'hF);

    op("load",      4'h6, 4'd0, 64'd10, 64'd20, 64'd0, 4'h8, 4'hF);
    drive("stl_bub", 4'h6, 4'd0, 64'd1, 64'd2, 64'd0, 4'h9, 4'hF, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    op("reload",    4'h3, 4'd0, 64'd0, 64'd0, 64'h1234, 4'hA, 4'hF);
    drive("stall1", 4'h3, 4'd0, 64'd0, 64'd0, 64'h5678, 4'hB, 4'hF, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("stall2", 4'h5, 4'd0, 64'd3, 64'd4, 64'h9, 4'hF, 4'hC, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("bubble", 4'h5, 4'd0, 64'd3, 64'd4, 64'h9, 4'hF, 4'hC, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ic = 4'($urandom_range(0, 11));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      drive("rand", ic, fn,
            {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            3'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      if (i == 30) begin
        do_reset();
        op("post_rst_je", 4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
